// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//   Single-issue ALU with a one-register result stage and an optional
//   iterative shift-add multiplier. Non-multiply operations are computed
//   combinationally and captured in the result register on the accepting
//   edge. Multiplies take WIDTH shift-add steps plus one finishing cycle.
//
// Parameters
//   WIDTH   datapath width (8, 16, 32 or 64)
//   MUL_EN  1 = iterative multiplier present, 0 = multiply requests act as ADD
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands/opcode presented
//   in_ready   block accepts on in_valid && in_ready
//   A, B       operands (shifts: A low bits = amount, B = shifted value)
//   ALUFun     6-bit operation code
//   Sign       signed arithmetic / overflow / compare
//   Mul        multiply request (ALUFun ignored)
//   out_valid  result available
//   out_ready  consumer takes the result
//   Z, Hi      result low word / high word (Hi nonzero only for multiply)
//   V          signed overflow of add/sub
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  input  logic             Mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Hi,
  output logic             V
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam logic MulOn = (MUL_EN != 0);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t             state_q;
  logic               outValid_q;
  logic [WIDTH-1:0]   z_q;
  logic [WIDTH-1:0]   hi_q;
  logic               v_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;

  logic               accept;
  logic               mulReq;
  logic [5:0]         fun;
  logic [WIDTH-1:0]   bEff;
  logic [WIDTH:0]     addRes;
  logic [WIDTH:0]     subRes;
  logic               addOvf;
  logic               subOvf;
  logic               ltFlag;
  logic               cmpBit;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   aluZ_d;
  logic               aluV_d;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [2*WIDTH-1:0] product_d;

  // Handshake: a new operation may only enter when the FSM is idle and the
  // result register is free (or being drained on this same edge).
  assign in_ready = (state_q == IDLE) && (!outValid_q || out_ready) && rst_n;
  assign accept   = in_valid && in_ready;
  assign mulReq   = Mul && MulOn;

  assign out_valid = outValid_q;
  assign Z         = z_q;
  assign Hi        = hi_q;
  assign V         = v_q;

  // Combinational ALU for all single-cycle operations. Without the
  // multiplier a multiply request is folded into a plain ADD. Compares share
  // the subtractor; LT uses N^V when signed and the borrow when unsigned.
  always_comb begin
    fun    = (Mul && !MulOn) ? 6'b000000 : ALUFun;
    bEff   = fun[3] ? '0 : B;
    addRes = {1'b0, A} + {1'b0, bEff};
    subRes = {1'b0, A} - {1'b0, bEff};
    addOvf = (A[WIDTH-1] == bEff[WIDTH-1]) && (addRes[WIDTH-1] != A[WIDTH-1]);
    subOvf = (A[WIDTH-1] != bEff[WIDTH-1]) && (subRes[WIDTH-1] != A[WIDTH-1]);
    ltFlag = Sign ? (subRes[WIDTH-1] ^ subOvf) : subRes[WIDTH];
    shamt  = A[SHW-1:0];
    cmpBit = 1'b0;
    aluZ_d = '0;
    aluV_d = 1'b0;
    case (fun[5:4])
      2'b00: begin
        aluZ_d = fun[0] ? subRes[WIDTH-1:0] : addRes[WIDTH-1:0];
        aluV_d = Sign && (fun[0] ? subOvf : addOvf);
      end
      2'b01: begin
        case (fun)
          6'b011000: aluZ_d = A & B;
          6'b011110: aluZ_d = A | B;
          6'b010110: aluZ_d = A ^ B;
          6'b010001: aluZ_d = ~(A | B);
          6'b011010: aluZ_d = A;
          default:   aluZ_d = '0;
        endcase
      end
      2'b10: begin
        case (fun[1:0])
          2'b00:   aluZ_d = B << shamt;
          2'b01:   aluZ_d = B >> shamt;
          2'b11:   aluZ_d = $unsigned($signed(B) >>> shamt);
          default: aluZ_d = '0;
        endcase
      end
      default: begin
        // LEZ/LTZ/GTZ look only at A, always as a signed value.
        case (fun)
          6'b110011: cmpBit = (subRes[WIDTH-1:0] == '0);
          6'b110001: cmpBit = (subRes[WIDTH-1:0] != '0);
          6'b110101: cmpBit = ltFlag;
          6'b111101: cmpBit = A[WIDTH-1] || (A == '0);
          6'b111011: cmpBit = A[WIDTH-1];
          6'b111111: cmpBit = !A[WIDTH-1] && (A != '0);
          default:   cmpBit = 1'b0;
        endcase
        aluZ_d = {{(WIDTH-1){1'b0}}, cmpBit};
      end
    endcase
  end

  // Operand magnitudes for the multiplier and the final sign correction.
  // Negating the most negative value yields its correct unsigned magnitude.
  always_comb begin
    aMag      = (Sign && A[WIDTH-1]) ? -A : A;
    bMag      = (Sign && B[WIDTH-1]) ? -B : B;
    product_d = neg_q ? -acc_q : acc_q;
  end

  // Control FSM and result register. IDLE either loads a single-cycle result
  // or launches a multiply; MUL does one shift-add step per cycle and uses a
  // final cycle (counter == WIDTH) to write the signed-corrected product.
  // The result register is only ever overwritten when it is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      z_q        <= '0;
      hi_q       <= '0;
      v_q        <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (mulReq) begin
              state_q    <= MUL;
              outValid_q <= 1'b0;
              mcand_q    <= {{WIDTH{1'b0}}, aMag};
              mplier_q   <= bMag;
              acc_q      <= '0;
              cnt_q      <= '0;
              neg_q      <= Sign && (A[WIDTH-1] ^ B[WIDTH-1]);
            end else begin
              outValid_q <= 1'b1;
              z_q        <= aluZ_d;
              hi_q       <= '0;
              v_q        <= aluV_d;
            end
          end else if (out_ready) begin
            outValid_q <= 1'b0;
          end
        end
        default: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_q    <= IDLE;
            outValid_q <= 1'b1;
            z_q        <= product_d[WIDTH-1:0];
            hi_q       <= product_d[2*WIDTH-1:WIDTH];
            v_q        <= 1'b0;
          end else begin
            if (mplier_q[0]) begin
              acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
